// File: rtl/rpn_pkg.sv
// Shared definitions for the RPN calculator display path: seven-segment
// glyphs (active-low {g,f,e,d,c,b,a}) and the display FSM state type.
package rpn_pkg;

    localparam logic [6:0] ZERO  = 7'b1000000;
    localparam logic [6:0] ONE   = 7'b1111001;
    localparam logic [6:0] TWO   = 7'b0100100;
    localparam logic [6:0] THREE = 7'b0110000;
    localparam logic [6:0] FOUR  = 7'b0011001;
    localparam logic [6:0] FIVE  = 7'b0010010;
    localparam logic [6:0] SIX   = 7'b0000010;
    localparam logic [6:0] SEVEN = 7'b1111000;
    localparam logic [6:0] EIGHT = 7'b0000000;
    localparam logic [6:0] NINE  = 7'b0010000;
    localparam logic [6:0] E     = 7'b0000110;
    localparam logic [6:0] r     = 7'b0101111;
    localparam logic [6:0] o     = 7'b0100011;
    localparam logic [6:0] OFF   = 7'b1111111;
    localparam logic [6:0] MINUS = 7'b0111111;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        ENCODE  = 2'd2
    } disp_state_t;

endpackage

// File: rtl/rpn_result_display_seg7_digit.sv
// One decimal digit to seven-segment glyph, with a blank override used for
// leading-zero suppression. Codes above nine never occur; they show OFF.
module seg7_digit
    import rpn_pkg::*;
(
    input  logic [3:0] bcd,
    input  logic       blank,
    output logic [6:0] seg
);

    // Glyph lookup; blank wins over the digit value
    always_comb begin
        seg = OFF;
        if (!blank) begin
            case (bcd)
                4'd0:    seg = ZERO;
                4'd1:    seg = ONE;
                4'd2:    seg = TWO;
                4'd3:    seg = THREE;
                4'd4:    seg = FOUR;
                4'd5:    seg = FIVE;
                4'd6:    seg = SIX;
                4'd7:    seg = SEVEN;
                4'd8:    seg = EIGHT;
                4'd9:    seg = NINE;
                default: seg = OFF;
            endcase
        end
    end

endmodule

// File: rtl/rpn_result_display.sv
// Converts the byte written back by the RPN core to decimal (double dabble,
// one bit per clock) and drives HEX5..HEX0 with sign, blanked digits or "Err".
module rpn_result_display
    import rpn_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int BCD_DIGITS = 3
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] value,
    input  logic             signed_mode,
    input  logic             err_in,
    output logic             busy,
    output logic             done,
    output logic [6:0]       HEX0,
    output logic [6:0]       HEX1,
    output logic [6:0]       HEX2,
    output logic [6:0]       HEX3,
    output logic [6:0]       HEX4,
    output logic [6:0]       HEX5
);

    localparam int BCD_W = 4 * BCD_DIGITS;
    localparam int CNT_W = $clog2(WIDTH + 1);

    disp_state_t       state_q, state_d;
    logic [BCD_W-1:0]  bcd_q, bcd_adj;
    logic [WIDTH-1:0]  mag_q, mag_in;
    logic [CNT_W-1:0]  cnt_q;
    logic              neg_q, err_q, neg_in, accept, cnt_last;
    logic [5:0][6:0]   hex_q, img_num, img_err;
    logic [6:0]        seg_h, seg_t, seg_u;
    logic              blank_h, blank_t;

    // A new request is only taken from IDLE; this includes the done cycle
    assign accept   = (state_q == IDLE) && load;
    assign cnt_last = (cnt_q == CNT_W'(WIDTH - 1));

    // Two's-complement negate in WIDTH bits: the most negative value comes
    // back as 2^(WIDTH-1), which reads correctly as an unsigned magnitude.
    assign neg_in = signed_mode & value[WIDTH-1];
    assign mag_in = neg_in ? (~value + {{(WIDTH-1){1'b0}}, 1'b1}) : value;

    // State register
    always_ff @(posedge CLOCK_50) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic; error requests skip the conversion entirely
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (load) state_d = err_in ? ENCODE : CONVERT;
            CONVERT: if (cnt_last) state_d = ENCODE;
            ENCODE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Add-3 correction on every BCD nibble that would overflow when doubled
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
    end

    assign blank_h = (bcd_q[11:8] == 4'd0);
    assign blank_t = blank_h && (bcd_q[7:4] == 4'd0);

    seg7_digit u_seg_h (.bcd(bcd_q[11:8]), .blank(blank_h), .seg(seg_h));
    seg7_digit u_seg_t (.bcd(bcd_q[7:4]),  .blank(blank_t), .seg(seg_t));
    seg7_digit u_seg_u (.bcd(bcd_q[3:0]),  .blank(1'b0),    .seg(seg_u));

    // Numeric image: minus sits just left of the most significant shown digit
    always_comb begin
        img_num    = {6{OFF}};
        img_num[2] = seg_h;
        img_num[1] = seg_t;
        img_num[0] = seg_u;
        if (neg_q) begin
            if (!blank_h)      img_num[3] = MINUS;
            else if (!blank_t) img_num[2] = MINUS;
            else               img_num[1] = MINUS;
        end
        img_err    = {6{OFF}};
        img_err[2] = E;
        img_err[1] = r;
        img_err[0] = r;
    end

    // Datapath, handshake and display registers; HEX only moves in ENCODE
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            busy  <= 1'b0;
            done  <= 1'b0;
            hex_q <= {6{OFF}};
            neg_q <= 1'b0;
            err_q <= 1'b0;
            bcd_q <= '0;
            mag_q <= '0;
            cnt_q <= '0;
        end else begin
            done <= 1'b0;
            case (state_q)
                IDLE: begin
                    busy <= accept;
                    if (accept) begin
                        err_q <= err_in;
                        neg_q <= neg_in;
                        mag_q <= mag_in;
                        bcd_q <= '0;
                        cnt_q <= '0;
                    end
                end
                CONVERT: begin
                    bcd_q <= {bcd_adj[BCD_W-2:0], mag_q[WIDTH-1]};
                    mag_q <= {mag_q[WIDTH-2:0], 1'b0};
                    cnt_q <= cnt_q + 1'b1;
                end
                ENCODE: begin
                    hex_q <= err_q ? img_err : img_num;
                    done  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign HEX0 = hex_q[0];
    assign HEX1 = hex_q[1];
    assign HEX2 = hex_q[2];
    assign HEX3 = hex_q[3];
    assign HEX4 = hex_q[4];
    assign HEX5 = hex_q[5];

endmodule
